// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared widths and register indices for the issue scoreboard.
package reg_scoreboard_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int XZR_IDX    = 31;
   localparam int LR_IDX     = 30;
   localparam int NREG       = 32;
   localparam int CNT_W      = 2;
   localparam int STALL_W    = 16;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode issue handshake plus write-back/flush traffic into the scoreboard.
interface reg_scoreboard_if;
   import reg_scoreboard_pkg::*;
   logic                  issue_valid;
   logic                  issue_ready;
   logic [REG_ADDR_W-1:0] src1;
   logic                  src1_used;
   logic [REG_ADDR_W-1:0] src2;
   logic                  src2_used;
   logic [REG_ADDR_W-1:0] dst;
   logic                  dst_used;
   logic                  wb_valid;
   logic [REG_ADDR_W-1:0] wb_reg;
   logic                  flush;
   modport master (output issue_valid, src1, src1_used, src2, src2_used, dst, dst_used,
                   wb_valid, wb_reg, flush, input issue_ready);
   modport slave  (input issue_valid, src1, src1_used, src2, src2_used, dst, dst_used,
                   wb_valid, wb_reg, flush, output issue_ready);
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: per-register pending-write counter; a decrement at zero is dropped and flagged.
module sb_counter import reg_scoreboard_pkg::*; #(
   parameter int W = CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   input  logic clr,
   output logic full,
   output logic nonzero,
   output logic last,
   output logic underflow
);
   logic [W-1:0] cnt;
   assign full      = &cnt;
   assign nonzero   = |cnt;
   assign last      = cnt == W'(1);
   assign underflow = dec & ~nonzero;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else     cnt <= clr ? '0 : cnt + W'(inc) - W'(dec & nonzero);
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: RAW/overflow issue gating over per-register pending-write counters (WB_BYPASS_EN lets a same-cycle wb clear the hazard).
module reg_scoreboard import reg_scoreboard_pkg::*; (
   input  logic               clk,
   input  logic               rst,
   reg_scoreboard_if.slave    sb,
   output logic [NREG-1:0]    busy_vec,
   output logic [STALL_W-1:0] stall_cnt,
   output logic               err_underflow
);
`ifdef WB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif
   logic [NREG-1:0] full_v, last_v, uf_v;
   logic fire, wb_ok, hazard, full;
   assign wb_ok = sb.wb_valid & ~sb.flush;
   assign fire  = sb.issue_valid & sb.issue_ready;
   for (genvar r = 0; r < XZR_IDX; r++) begin : g_cnt
      sb_counter u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc       (fire & sb.dst_used & (sb.dst == REG_ADDR_W'(r))),
         .dec       (wb_ok & (sb.wb_reg == REG_ADDR_W'(r))),
         .clr       (sb.flush),
         .full      (full_v[r]),
         .nonzero   (busy_vec[r]),
         .last      (last_v[r]),
         .underflow (uf_v[r])
      );
   end
   // XZR has no counter: never busy, never full
   assign full_v[XZR_IDX]   = 1'b0;
   assign busy_vec[XZR_IDX] = 1'b0;
   assign last_v[XZR_IDX]   = 1'b0;
   assign uf_v[XZR_IDX]     = 1'b0;
   assign hazard = (sb.src1_used & busy_vec[sb.src1] &
                    ~(BYP & sb.wb_valid & (sb.wb_reg == sb.src1) & last_v[sb.src1])) |
                   (sb.src2_used & busy_vec[sb.src2] &
                    ~(BYP & sb.wb_valid & (sb.wb_reg == sb.src2) & last_v[sb.src2]));
   assign full = sb.dst_used & full_v[sb.dst] & ~(BYP & sb.wb_valid & (sb.wb_reg == sb.dst));
   assign sb.issue_ready = ~hazard & ~full & ~sb.flush;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         stall_cnt     <= '0;
         err_underflow <= 1'b0;
      end else begin
         if (sb.issue_valid & ~sb.issue_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
         if (|uf_v) err_underflow <= 1'b1;
      end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed scenario tasks with hand-computed expectations for reg_scoreboard.
module tb_reg_scoreboard;
   import reg_scoreboard_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NREG-1:0]    busy_vec;
   logic [STALL_W-1:0] stall_cnt;
   logic               err_underflow;
   int passed = 0;
   int total  = 0;
   reg_scoreboard_if sb ();
   reg_scoreboard dut (
      .clk           (clk),
      .rst           (rst),
      .sb            (sb),
      .busy_vec      (busy_vec),
      .stall_cnt     (stall_cnt),
      .err_underflow (err_underflow)
   );
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      sb.issue_valid = 0; sb.src1 = 0; sb.src1_used = 0; sb.src2 = 0; sb.src2_used = 0;
      sb.dst = 0; sb.dst_used = 0; sb.wb_valid = 0; sb.wb_reg = 0; sb.flush = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      step();
      rst = 0;
      step();
      total++; if (busy_vec !== 32'h0) $display("FAIL reset_busy got=%h exp=0", busy_vec); else passed++;
      total++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall got=%0d exp=0", stall_cnt); else passed++;
      total++; if (err_underflow !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_underflow); else passed++;
      total++; if (sb.issue_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", sb.issue_ready); else passed++;
   endtask

   task automatic test_raw();
      logic [STALL_W-1:0] exp_stall;
      sb.issue_valid = 1; sb.dst_used = 1; sb.dst = 5;
      #1;
      total++; if (sb.issue_ready !== 1'b1) $display("FAIL raw_issue_ready got=%b exp=1", sb.issue_ready); else passed++;
      step();
      total++; if (busy_vec !== 32'h20) $display("FAIL raw_busy5 got=%h exp=00000020", busy_vec); else passed++;
      sb.dst_used = 0; sb.src1 = 5; sb.src1_used = 1;
      #1;
      total++; if (sb.issue_ready !== 1'b0) $display("FAIL raw_hazard got=%b exp=0", sb.issue_ready); else passed++;
      for (int i = 1; i <= 3; i++) begin
         step();
         total++; if (stall_cnt !== STALL_W'(i)) $display("FAIL raw_stall%0d got=%0d exp=%0d", i, stall_cnt, i); else passed++;
      end
      sb.wb_valid = 1; sb.wb_reg = 5;
      #1;
`ifdef WB_BYPASS_EN
      total++; if (sb.issue_ready !== 1'b1) $display("FAIL raw_wb_cycle got=%b exp=1", sb.issue_ready); else passed++;
      exp_stall = 16'd3;
`else
      total++; if (sb.issue_ready !== 1'b0) $display("FAIL raw_wb_cycle got=%b exp=0", sb.issue_ready); else passed++;
      exp_stall = 16'd4;
`endif
      step();
      sb.wb_valid = 0;
      #1;
      total++; if (sb.issue_ready !== 1'b1) $display("FAIL raw_after_wb got=%b exp=1", sb.issue_ready); else passed++;
      total++; if (busy_vec !== 32'h0) $display("FAIL raw_busy_clear got=%h exp=0", busy_vec); else passed++;
      total++; if (stall_cnt !== exp_stall) $display("FAIL raw_stall_final got=%0d exp=%0d", stall_cnt, exp_stall); else passed++;
      idle();
      step();
   endtask

   task automatic test_xzr();
      sb.issue_valid = 1; sb.dst_used = 1; sb.dst = 31;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (sb.issue_ready !== 1'b1) $display("FAIL xzr_dst%0d got=%b exp=1", i, sb.issue_ready); else passed++;
         step();
      end
      total++; if (busy_vec !== 32'h0) $display("FAIL xzr_busy got=%h exp=0", busy_vec); else passed++;
      sb.dst_used = 0; sb.src1 = 31; sb.src1_used = 1; sb.src2 = 31; sb.src2_used = 1;
      #1;
      total++; if (sb.issue_ready !== 1'b1) $display("FAIL xzr_src got=%b exp=1", sb.issue_ready); else passed++;
      step();
      idle();
   endtask

   task automatic test_full();
      sb.issue_valid = 1; sb.dst_used = 1; sb.dst = 7;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (sb.issue_ready !== 1'b1) $display("FAIL full_fill%0d got=%b exp=1", i, sb.issue_ready); else passed++;
         step();
      end
      #1;
      total++; if (sb.issue_ready !== 1'b0) $display("FAIL full_at_max got=%b exp=0", sb.issue_ready); else passed++;
      total++; if (busy_vec !== 32'h80) $display("FAIL full_busy7 got=%h exp=00000080", busy_vec); else passed++;
      sb.issue_valid = 0; sb.wb_valid = 1; sb.wb_reg = 7;
      step();
      sb.issue_valid = 1;
      #1;
      total++; if (sb.issue_ready !== 1'b1) $display("FAIL full_fire_wb got=%b exp=1", sb.issue_ready); else passed++;
      step();
      sb.wb_valid = 0;
      #1;
      total++; if (sb.issue_ready !== 1'b1) $display("FAIL full_still2 got=%b exp=1", sb.issue_ready); else passed++;
      step();
      #1;
      total++; if (sb.issue_ready !== 1'b0) $display("FAIL full_back3 got=%b exp=0", sb.issue_ready); else passed++;
      sb.issue_valid = 0; sb.wb_valid = 1;
      for (int i = 0; i < 3; i++) step();
      sb.wb_valid = 0;
      total++; if (busy_vec !== 32'h0) $display("FAIL full_drain got=%h exp=0", busy_vec); else passed++;
      idle();
   endtask

   task automatic test_underflow();
      sb.wb_valid = 1; sb.wb_reg = 9;
      step();
      sb.wb_valid = 0;
      total++; if (err_underflow !== 1'b1) $display("FAIL uf_set got=%b exp=1", err_underflow); else passed++;
      total++; if (busy_vec !== 32'h0) $display("FAIL uf_busy got=%h exp=0", busy_vec); else passed++;
      sb.issue_valid = 1; sb.dst_used = 1; sb.dst = 3;
      step();
      idle();
      sb.wb_valid = 1; sb.wb_reg = 3;
      step();
      idle();
      step();
      total++; if (err_underflow !== 1'b1) $display("FAIL uf_sticky got=%b exp=1", err_underflow); else passed++;
   endtask

   task automatic test_flush();
      sb.issue_valid = 1; sb.dst_used = 1;
      sb.dst = 3;  step();
      sb.dst = 10; step();
      sb.dst = 30; step();
      idle();
      total++; if (busy_vec !== 32'h4000_0408) $display("FAIL fl_pending got=%h exp=40000408", busy_vec); else passed++;
      sb.flush = 1; sb.issue_valid = 1; sb.dst_used = 1; sb.dst = 12; sb.wb_valid = 1; sb.wb_reg = 3;
      #1;
      total++; if (sb.issue_ready !== 1'b0) $display("FAIL fl_ready got=%b exp=0", sb.issue_ready); else passed++;
      step();
      idle();
      total++; if (busy_vec !== 32'h0) $display("FAIL fl_busy got=%h exp=0", busy_vec); else passed++;
      total++; if (err_underflow !== 1'b1) $display("FAIL fl_err got=%b exp=1", err_underflow); else passed++;
   endtask

   task automatic test_async_reset();
      sb.issue_valid = 1; sb.dst_used = 1; sb.dst = 4;
      step(); step();
      sb.dst_used = 0; sb.src1 = 4; sb.src1_used = 1;
      step(); step();
      total++; if (busy_vec !== 32'h10) $display("FAIL ar_busy4 got=%h exp=00000010", busy_vec); else passed++;
      total++; if (stall_cnt === 16'd0) $display("FAIL ar_stalling got=%0d exp=nonzero", stall_cnt); else passed++;
      #2;
      rst = 1;
      #1;
      total++; if (busy_vec !== 32'h0) $display("FAIL ar_busy got=%h exp=0", busy_vec); else passed++;
      total++; if (stall_cnt !== 16'd0) $display("FAIL ar_stall got=%0d exp=0", stall_cnt); else passed++;
      total++; if (err_underflow !== 1'b0) $display("FAIL ar_err got=%b exp=0", err_underflow); else passed++;
      total++; if (sb.issue_ready !== 1'b1) $display("FAIL ar_ready got=%b exp=1", sb.issue_ready); else passed++;
      idle();
      step();
      rst = 0;
      step();
   endtask

   initial begin
      test_reset();
      test_raw();
      test_xzr();
      test_full();
      test_underflow();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-file scoreboard and issue controller for the decode stage. Tracks outstanding writes to each architectural register and gates instruction issue so no instruction reads a register with a pending write (RAW) or overflows a register's pending-write counter. Sits between fetch/decode and the register-file read ports. Driven by decode on issue and by write-back on register-file writes.

## Interface
- NREG, 32, number of architectural registers; index 31 is XZR, index 30 is the link register
- CNT_W, 2, width of the per-register pending-write counter; max outstanding = 2^CNT_W-1
- STALL_W, 16, width of the stall-cycle counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  scoreboard accepts it; fire = issue_valid & issue_ready
- src1  in  5  first source register (inst[9:5])
- src1_used  in  1  src1 is read
- src2  in  5  second source register (post-Reg2Loc select)
- src2_used  in  1  src2 is read
- dst  in  5  destination register (post-WRegLoc select)
- dst_used  in  1  instruction writes dst (RegWrite)
- wb_valid  in  1  write-back retires one write this cycle
- wb_reg  in  5  register being written
- flush  in  1  discard all in-flight writes
- busy_vec  out  NREG  bit r = pending count of r nonzero
- stall_cnt  out  STALL_W  saturating count of cycles with issue_valid & ~issue_ready
- err_underflow  out  1  sticky; wb to a register with count 0

## Operation
- Per-register counter cnt[r]; cnt[31] hard-wired 0; dst==31 or src==31 never pending/hazard.
- hazard = (src1_used & cnt[src1]!=0) | (src2_used & cnt[src2]!=0).
- full = dst_used & dst!=31 & cnt[dst]==max.
- issue_ready = ~hazard & ~full & ~flush (combinational from state and inputs).
- On fire with dst_used & dst!=31: cnt[dst] += 1.
- On wb_valid & wb_reg!=31: cnt[wb_reg] -= 1 if nonzero; if zero, count unchanged and err_underflow set.
- Fire and wb to same register in one cycle: count unchanged (+1-1); full check still uses pre-update count.
- flush: all counters cleared next edge; wb and issue in flush cycle ignored; err_underflow not affected.
- stall_cnt increments when issue_valid & ~issue_ready, saturates at all-ones; cleared only by rst.
- err_underflow cleared only by rst.

## Timing
- Reset values: all cnt 0, busy_vec 0, stall_cnt 0, err_underflow 0; issue_ready therefore 1 (absent flush) immediately after reset.
- Reset asserted mid-operation clears all state asynchronously; in-flight writes are forgotten.
- Counter updates visible on busy_vec and issue_ready one cycle after the fire/wb edge.
- issue_ready has zero latency from issue inputs (same-cycle combinational).
- Without bypass, a dependent instruction issues no earlier than the cycle after the retiring wb.

## Configuration
- WB_BYPASS_EN defined: hazard on a source ignores a same-cycle wb_valid to that register when its cnt==1 (register file writes before reads); same for full check on dst with cnt==max. Dependent instruction issues in the wb cycle.
- Undefined: no bypass; hazard uses registered counts only.

## Structure
- Shared package: REG_ADDR_W=5, XZR_IDX=31, LR_IDX=30, NREG default, CNT_W default.
- Sub-module sb_counter: one CNT_W up/down counter with inc, dec, clr, full, nonzero, underflow outputs; instantiated NREG-1 times (index 31 tied off).

## Test plan
- Reset, issue dst=5 -> next cycle busy_vec[5]=1; issue src1=5 held -> issue_ready=0, stall_cnt counts 1,2,3; wb_reg=5 -> ready next cycle (same cycle with WB_BYPASS_EN).
- Issue dst=31 three times, then src1=31 -> busy_vec=0, ready always 1.
- CNT_W=2: issue dst=7 three times -> cnt=3; fourth issue ready=0 (full); fire + wb to 7 same cycle at cnt=2 -> cnt stays 2.
- wb_reg=9 with cnt[9]=0 -> err_underflow=1 and remains 1 after further traffic; busy_vec unchanged.
- Pending on 3, 10, 30; pulse flush with issue_valid and wb_valid high -> no fire, busy_vec=0 next cycle.
- Assert rst mid-stall with cnt[4]=2 -> busy_vec=0, stall_cnt=0, issue_ready=1 immediately.
